// File: rtl/mips_core_pkg.sv
// Shared rename-stage types: physical tag, free-list pointer and register-file sizes.
package mips_core_pkg;

  localparam int unsigned PHYS_REG_COUNT = 64;
  localparam int unsigned ARCH_REG_COUNT = 32;
  localparam int unsigned PHYS_TAG_W     = $clog2(PHYS_REG_COUNT);
  localparam int unsigned FL_PTR_W       = PHYS_TAG_W + 1;

  typedef logic [PHYS_TAG_W-1:0] MipsLogic;
  typedef logic [FL_PTR_W-1:0]   FreeListPtr;

  // Storage index of a wrap-extended pointer.
  function automatic MipsLogic ptr_idx(input FreeListPtr ptr);
    return ptr[PHYS_TAG_W-1:0];
  endfunction

endpackage

// File: rtl/free_list_ram.sv
// Free-list tag storage: one synchronous write port, one asynchronous read port.
// Reset loads entry i with tag (i + ResetOffset) mod Depth so the free region holds the unmapped tags.
module free_list_ram
  import mips_core_pkg::*;
#(
  parameter int unsigned Depth       = PHYS_REG_COUNT,
  parameter int unsigned ResetOffset = ARCH_REG_COUNT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     we_i,
  input  MipsLogic waddr_i,
  input  MipsLogic wdata_i,
  input  MipsLogic raddr_i,
  output MipsLogic rdata_o
);

  MipsLogic mem_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= MipsLogic'((i + ResetOffset) % Depth);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical tags: rename allocates at head, commit frees at tail.
// Optional head checkpoint/restore is built when FREE_LIST_CHECKPOINT_EN is defined.
module phys_reg_free_list
  import mips_core_pkg::*;
#(
  parameter int unsigned NUM_PHYS = PHYS_REG_COUNT,
  parameter int unsigned NUM_ARCH = ARCH_REG_COUNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_valid,
  output MipsLogic            alloc_tag,
  input  logic                free_valid,
  input  MipsLogic            free_tag,
`ifdef FREE_LIST_CHECKPOINT_EN
  input  logic                ckpt_take,
  input  logic                ckpt_restore,
`endif
  output logic [FL_PTR_W-1:0] free_count,
  output logic                overflow_err,
  output logic                underflow_err
);

  FreeListPtr head_q, head_d;
  FreeListPtr tail_q, tail_d;
  FreeListPtr count;
  logic       overflow_q, overflow_d;
  logic       underflow_q, underflow_d;
  logic       full;
  logic       alloc_fire;
  logic       free_fire;
  logic       restore;

  assign count       = tail_q - head_q;
  assign full        = (count == FreeListPtr'(NUM_PHYS));
  assign alloc_valid = (count != '0);
  assign free_count  = count;

`ifdef FREE_LIST_CHECKPOINT_EN
  FreeListPtr ckpt_q, ckpt_d;
  assign restore = ckpt_restore;
`else
  assign restore = 1'b0;
`endif

  // A restore rewinds head, so any allocate in that cycle is discarded.
  assign alloc_fire = alloc_req && alloc_valid && !restore;
  // p0 is the permanent $zero mapping and never re-enters the list.
  assign free_fire  = free_valid && (free_tag != '0) && !full;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

`ifdef FREE_LIST_CHECKPOINT_EN
    if (restore) begin
      head_d = ckpt_q;
    end else if (alloc_fire) begin
      head_d = head_q + FreeListPtr'(1);
    end
`else
    if (alloc_fire) begin
      head_d = head_q + FreeListPtr'(1);
    end
`endif

    if (free_fire) begin
      tail_d = tail_q + FreeListPtr'(1);
    end

    if (free_valid && (free_tag != '0) && full) begin
      overflow_d = 1'b1;
    end
    if (alloc_req && !alloc_valid) begin
      underflow_d = 1'b1;
    end
  end

`ifdef FREE_LIST_CHECKPOINT_EN
  // The checkpoint captures the head as it will be after this edge.
  always_comb begin
    ckpt_d = ckpt_q;
    if (ckpt_take) begin
      ckpt_d = head_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ckpt_q <= '0;
    end else begin
      ckpt_q <= ckpt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= FreeListPtr'(NUM_PHYS - NUM_ARCH);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  free_list_ram #(
    .Depth       (NUM_PHYS),
    .ResetOffset (NUM_ARCH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (free_fire),
    .waddr_i (ptr_idx(tail_q)),
    .wdata_i (free_tag),
    .raddr_i (ptr_idx(head_q)),
    .rdata_o (alloc_tag)
  );

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: expected grant tags are queued by the stimulus
// and popped by a monitor on every granted allocate; state checks are directed.
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_tag;
  logic       free_valid;
  logic [5:0] free_tag;
  logic [6:0] free_count;
  logic       overflow_err;
  logic       underflow_err;
`ifdef FREE_LIST_CHECKPOINT_EN
  logic       ckpt_take;
  logic       ckpt_restore;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q [$];
  logic [5:0] model_q [$];

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_valid   (alloc_valid),
    .alloc_tag     (alloc_tag),
    .free_valid    (free_valid),
    .free_tag      (free_tag),
`ifdef FREE_LIST_CHECKPOINT_EN
    .ckpt_take     (ckpt_take),
    .ckpt_restore  (ckpt_restore),
`endif
    .free_count    (free_count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  logic in_restore;
`ifdef FREE_LIST_CHECKPOINT_EN
  assign in_restore = ckpt_restore;
`else
  assign in_restore = 1'b0;
`endif

  // Monitor: every granted allocate must return the next queued tag.
  always @(negedge clk) begin
    if (!rst && alloc_req && alloc_valid && !in_restore) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got tag %0d, no grant expected", alloc_tag);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (alloc_tag !== e) begin
          errors++;
          $display("FAIL grant_tag: got %0d expected %0d", alloc_tag, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic alloc_one(input logic [5:0] exp_tag);
    alloc_req = 1'b1;
    exp_q.push_back(exp_tag);
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic free_one(input logic [5:0] tag);
    free_valid = 1'b1;
    free_tag   = tag;
    tick();
    free_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = '0;
`ifdef FREE_LIST_CHECKPOINT_EN
    ckpt_take    = 1'b0;
    ckpt_restore = 1'b0;
`endif
    #12;
    rst = 1'b0;
    #1;

    // Reset image
    check("rst_count", free_count, 32);
    check("rst_valid", alloc_valid, 1);
    check("rst_tag", alloc_tag, 32);
    check("rst_ovf", overflow_err, 0);
    check("rst_unf", underflow_err, 0);

    // Drain all 32 free tags in order
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      exp_q.push_back(6'(32 + i));
      tick();
    end
    alloc_req = 1'b0;
    check("drain_count", free_count, 0);
    check("drain_valid", alloc_valid, 0);
    check("drain_unf_before", underflow_err, 0);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    check("underflow_set", underflow_err, 1);
    check("underflow_count", free_count, 0);

    // Empty list: a same-cycle free does not satisfy the alloc
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd40;
    tick();
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    check("nobypass_valid", alloc_valid, 1);
    check("nobypass_tag", alloc_tag, 40);
    check("nobypass_count", free_count, 1);
    alloc_one(6'd40);
    check("after40_count", free_count, 0);
    check("underflow_sticky", underflow_err, 1);

    // Fill to full; p0 is dropped
    do_reset();
    check("rst2_unf", underflow_err, 0);
    for (int t = 1; t < 32; t++) free_one(6'(t));
    free_one(6'd0);
    check("fill_count63", free_count, 63);
    free_one(6'd5);
    check("fill_count64", free_count, 64);
    check("full_ovf_before", overflow_err, 0);
    free_one(6'd7);
    check("overflow_set", overflow_err, 1);
    check("overflow_count", free_count, 64);

    // FIFO order across the wrap: p32..p63, p1..p31, p5
    for (int i = 0; i < 32; i++) alloc_one(6'(32 + i));
    for (int t = 1; t < 32; t++) alloc_one(6'(t));
    alloc_one(6'd5);
    check("wrap_empty", free_count, 0);
    check("overflow_sticky", overflow_err, 1);

    // Steady state: count 10, simultaneous alloc/free for 100 cycles
    model_q.delete();
    for (int t = 10; t < 20; t++) begin
      free_one(6'(t));
      model_q.push_back(6'(t));
    end
    check("steady_start", free_count, 10);
    for (int i = 0; i < 100; i++) begin
      logic [5:0] nt;
      nt = 6'(1 + ((i * 7) % 63));
      alloc_req  = 1'b1;
      free_valid = 1'b1;
      free_tag   = nt;
      exp_q.push_back(model_q.pop_front());
      model_q.push_back(nt);
      tick();
    end
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    check("steady_count", free_count, 10);
    check("steady_head_tag", alloc_tag, model_q[0]);

`ifdef FREE_LIST_CHECKPOINT_EN
    // Checkpoint: take at p32, alloc 5 with one free, restore
    do_reset();
    ckpt_take = 1'b1;
    tick();
    ckpt_take = 1'b0;
    for (int i = 0; i < 5; i++) alloc_one(6'(32 + i));
    free_one(6'd3);
    check("ckpt_mid_count", free_count, 28);
    ckpt_restore = 1'b1;
    alloc_req    = 1'b1;
    tick();
    ckpt_restore = 1'b0;
    alloc_req    = 1'b0;
    check("ckpt_tag", alloc_tag, 32);
    check("ckpt_count", free_count, 33);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
